// File: rtl/mem_req_arbiter.sv
// Two-port (fetch + load/store) arbiter onto one sram-like memory port with an in-order tag FIFO.
// Optional round-robin grant when ARB_RR_EN is defined; the default build uses fixed data priority.
module mem_req_arbiter #(
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int               PTR_W    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

    logic [CNT_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [MAX_OUT-1:0] tag_reg;

    logic can_issue;
    logic sel_data;
    logic push;
    logic pop;
    logic head_tag;

    // Pointers wrap at MAX_OUT, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

`ifdef ARB_RR_EN
    logic last_grant_reg;

    // With both sources requesting, the one not granted last time wins.
    always_comb begin
        sel_data = data_req & (~inst_req | ~last_grant_reg);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant_reg <= 1'b0;
        end else if (push) begin
            last_grant_reg <= sel_data;
        end
    end
`else
    always_comb begin
        sel_data = data_req;
    end
`endif

    always_comb begin
        can_issue = (count_reg < MAX_CNT);
        mem_req   = resetn & can_issue & (inst_req | data_req);

        if (sel_data) begin
            mem_wr    = data_wr;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_size  = data_size;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = 1'b0;
            mem_wstrb = 4'h0;
            mem_addr  = inst_addr;
            mem_size  = 3'd2;
            mem_wdata = 32'h0;
        end

        data_addr_ok = mem_addr_ok & mem_req & sel_data;
        inst_addr_ok = mem_addr_ok & mem_req & ~sel_data;
    end

    // Responses with nothing outstanding are stray and dropped.
    always_comb begin
        push         = mem_req & mem_addr_ok;
        pop          = resetn & mem_data_ok & (count_reg != '0);
        head_tag     = tag_reg[rd_ptr_reg];
        data_data_ok = pop & head_tag;
        inst_data_ok = pop & ~head_tag;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Tag bit per slot: 1 = load/store, 0 = fetch.
    for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_tag
        always_ff @(posedge clk) begin
            if (!resetn) begin
                tag_reg[gi] <= 1'b0;
            end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                tag_reg[gi] <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: cycle vector table plus scoreboard-driven sequences.
// Define ARB_RR_EN for both RTL and bench to exercise the round-robin grant sequence.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [2:0]  data_size;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [2:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.MAX_OUT(2), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_size(data_size), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        logic        rn, ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da;
        logic        ma, md;
        logic [31:0] mr;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic        e_mwr, e_iack, e_dack, e_idok, e_ddok;
    } vec_t;

    vec_t vecs[$];
    bit   src_q[$];

    function automatic vec_t mk(input string nm, input logic rn, ir, input logic [31:0] ia,
                                input logic dr, dw, input logic [31:0] da,
                                input logic ma, md, input logic [31:0] mr,
                                input logic e_mreq, input logic [31:0] e_maddr,
                                input logic e_mwr, e_iack, e_dack, e_idok, e_ddok);
        vec_t v;
        v.name = nm; v.rn = rn; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
        v.ma = ma; v.md = md; v.mr = mr; v.e_mreq = e_mreq; v.e_maddr = e_maddr;
        v.e_mwr = e_mwr; v.e_iack = e_iack; v.e_dack = e_dack; v.e_idok = e_idok; v.e_ddok = e_ddok;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; callers sample 2 units later.
    task automatic drive(input logic rn, ir, input logic [31:0] ia, input logic dr, dw,
                         input logic [31:0] da, input logic ma, md, input logic [31:0] mr);
        @(posedge clk);
        #1;
        resetn = rn; inst_req = ir; inst_addr = ia;
        data_req = dr; data_wr = dw; data_addr = da;
        mem_addr_ok = ma; mem_data_ok = md; mem_rdata = mr;
        #2;
    endtask

    // One scoreboard cycle: request from src (if req), optionally return one response.
    task automatic sb_cycle(input string nm, input logic req, input bit src, input logic [31:0] addr,
                            input logic md, input logic [31:0] mr);
        bit exp_src;
        drive(1'b1, req & ~src, addr, req & src, 1'b0, addr, 1'b1, md, mr);
        if (md) begin
            exp_src = src_q.pop_front();
            chk({nm, "_idok"}, inst_data_ok, !exp_src);
            chk({nm, "_ddok"}, data_data_ok, exp_src);
            chk({nm, "_rdata"}, exp_src ? data_rdata : inst_rdata, mr);
        end
        if (req) begin
            chk({nm, "_mreq"}, mem_req, 1'b1);
            chk({nm, "_maddr"}, mem_addr, addr);
            chk({nm, "_iack"}, inst_addr_ok, !src);
            chk({nm, "_dack"}, data_addr_ok, src);
            src_q.push_back(src);
        end
        $display("sb %s req=%0d src=%0d pop=%0d", nm, req, src, md);
    endtask

    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_addr = '0;
        data_wstrb = 4'hF; data_size = 3'd2; data_wdata = 32'hDEADBEEF;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

        //                 name         rn ir ia            dr dw da            ma md mr            mreq maddr        mwr iack dack idok ddok
        vecs.push_back(mk("reset",      0, 1, 32'hBFC00000, 1, 1, 32'h80001000, 1, 1, 32'h0,        0, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(mk("fetch_req",  1, 1, 32'hBFC00000, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00000, 0, 1, 0, 0, 0));
        vecs.push_back(mk("fetch_rsp",  1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h24080001, 0, 32'h0,        0, 0, 0, 1, 0));
        vecs.push_back(mk("both_data",  1, 1, 32'hBFC00004, 1, 1, 32'h80001000, 1, 0, 32'h0,        1, 32'h80001000, 1, 0, 1, 0, 0));
        vecs.push_back(mk("both_inst",  1, 1, 32'hBFC00004, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00004, 0, 1, 0, 0, 0));
        vecs.push_back(mk("rsp_data",   1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h11111111, 0, 32'h0,        0, 0, 0, 0, 1));
        vecs.push_back(mk("rsp_inst",   1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h22222222, 0, 32'h0,        0, 0, 0, 1, 0));
        vecs.push_back(mk("fill_1",     1, 1, 32'h000000A0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h000000A0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("fill_2",     1, 1, 32'h000000A4, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h000000A4, 0, 1, 0, 0, 0));
        vecs.push_back(mk("full",       1, 1, 32'h000000A8, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(mk("full_pop",   1, 1, 32'h000000A8, 0, 0, 32'h0,        1, 1, 32'h33333333, 0, 32'h0,        0, 0, 0, 1, 0));
        vecs.push_back(mk("resume",     1, 1, 32'h000000A8, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h000000A8, 0, 1, 0, 0, 0));
        vecs.push_back(mk("drain_1",    1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h44444444, 0, 32'h0,        0, 0, 0, 1, 0));
        vecs.push_back(mk("drain_2",    1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h55555555, 0, 32'h0,        0, 0, 0, 1, 0));
        vecs.push_back(mk("stray",      1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h66666666, 0, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(mk("no_ack",     1, 1, 32'h000000B0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h000000B0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rn, vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da,
                  vecs[i].ma, vecs[i].md, vecs[i].mr);
            chk({vecs[i].name, "_mreq"}, mem_req, vecs[i].e_mreq);
            chk({vecs[i].name, "_iack"}, inst_addr_ok, vecs[i].e_iack);
            chk({vecs[i].name, "_dack"}, data_addr_ok, vecs[i].e_dack);
            chk({vecs[i].name, "_idok"}, inst_data_ok, vecs[i].e_idok);
            chk({vecs[i].name, "_ddok"}, data_data_ok, vecs[i].e_ddok);
            if (vecs[i].e_mreq) begin
                chk({vecs[i].name, "_maddr"}, mem_addr, vecs[i].e_maddr);
                chk({vecs[i].name, "_mwr"}, mem_wr, vecs[i].e_mwr);
                chk({vecs[i].name, "_msize"}, mem_size, 3'd2);
                chk({vecs[i].name, "_mwstrb"}, mem_wstrb, vecs[i].e_mwr ? 4'hF : 4'h0);
                chk({vecs[i].name, "_mwdata"}, mem_wdata, vecs[i].e_mwr ? 32'hDEADBEEF : 32'h0);
            end
            if (vecs[i].rn) begin
                chk({vecs[i].name, "_irdata"}, inst_rdata, vecs[i].mr);
                chk({vecs[i].name, "_drdata"}, data_rdata, vecs[i].mr);
            end
            $display("vec %0d %s", i, vecs[i].name);
        end

        // Eight alternating transactions, each accept paired with the previous response.
        for (int k = 0; k <= 8; k++) begin
            sb_cycle($sformatf("alt%0d", k), k < 8, bit'(k % 2), 32'h1000 + 32'(k) * 4,
                     k >= 1, 32'hC0DE0000 + 32'(k));
        end

        // Build up pointer state, reset with two outstanding, confirm a clean restart.
        sb_cycle("rst_a", 1'b1, 1'b0, 32'h3000, 1'b0, 32'h0);
        sb_cycle("rst_b", 1'b1, 1'b1, 32'h4000, 1'b0, 32'h0);
        sb_cycle("rst_c", 1'b0, 1'b0, 32'h0,    1'b1, 32'h00000055);
        sb_cycle("rst_d", 1'b1, 1'b1, 32'h4004, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h3004, 1'b1, 1'b0, 32'h4008, 1'b1, 1'b1, 32'h77);
        chk("inrst_mreq", mem_req, 1'b0);
        chk("inrst_iack", inst_addr_ok, 1'b0);
        chk("inrst_dack", data_addr_ok, 1'b0);
        chk("inrst_idok", inst_data_ok, 1'b0);
        chk("inrst_ddok", data_data_ok, 1'b0);
        $display("seq reset_held");
        src_q.delete();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h88);
        chk("post_rst_stray_idok", inst_data_ok, 1'b0);
        chk("post_rst_stray_ddok", data_data_ok, 1'b0);
        $display("seq post_reset_stray");
        sb_cycle("post_rst_req", 1'b1, 1'b0, 32'h3100, 1'b0, 32'h0);
        sb_cycle("post_rst_rsp", 1'b0, 1'b0, 32'h0,    1'b1, 32'h00000066);

`ifdef ARB_RR_EN
        // A lone data accept leaves last_grant at data, so contention starts with inst.
        sb_cycle("rr_pre", 1'b1, 1'b1, 32'h5000, 1'b0, 32'h0);
        sb_cycle("rr_pre_rsp", 1'b0, 1'b0, 32'h0, 1'b1, 32'h99);
        for (int j = 0; j < 4; j++) begin
            bit exp_src;
            exp_src = bit'(j % 2);
            drive(1'b1, 1'b1, 32'h6000 + 32'(j) * 4, 1'b1, 1'b0, 32'h7000 + 32'(j) * 4,
                  1'b1, j > 0, 32'hAB000000 + 32'(j));
            if (j > 0) begin
                chk($sformatf("rr%0d_idok", j), inst_data_ok, !src_q[0]);
                chk($sformatf("rr%0d_ddok", j), data_data_ok, src_q[0]);
                void'(src_q.pop_front());
            end
            chk($sformatf("rr%0d_iack", j), inst_addr_ok, !exp_src);
            chk($sformatf("rr%0d_dack", j), data_addr_ok, exp_src);
            src_q.push_back(exp_src);
            $display("rr %0d expect_src=%0d", j, exp_src);
        end
        sb_cycle("rr_flush", 1'b0, 1'b0, 32'h0, 1'b1, 32'hABFFFFFF);
`endif

        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one sram-like memory port between the CPU fetch port (inst_*) and the CPU load/store port (data_*).
- Sits between mips_cpu and the single memory bridge.
- Forwards one address phase per cycle and records the source of each accepted request in an in-order tag FIFO.
- Routes each returning data_ok/rdata to the source at the FIFO head.

Parameters:
- MAX_OUT, 2, maximum accepted-but-not-completed transactions (1..8).
- CNT_W, 2, width of the outstanding counter; must hold MAX_OUT.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request
- data_wr  in  1  1=store
- data_wstrb  in  4  byte strobes
- data_addr  in  32  load/store address
- data_size  in  3  access size
- data_wdata  in  32  store data
- data_addr_ok  out  1  load/store address accepted
- data_data_ok  out  1  load data valid / store done
- data_rdata  out  32  load data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write
- mem_wstrb  out  4  downstream strobes
- mem_addr  out  32  downstream address
- mem_size  out  3  downstream size
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream address accepted
- mem_data_ok  in  1  downstream data valid
- mem_rdata  in  32  downstream read data

Behaviour:
- Single clock clk. Reset is synchronous, active-low on resetn.
- Reset clears: outstanding count = 0, FIFO rd/wr pointers = 0, last_grant = INST.
- While resetn=0, all outputs are 0: mem_req, *_addr_ok, *_data_ok.
- Address-phase grant is combinational, same cycle, no added latency:
  - can_issue = (count < MAX_OUT).
  - Without ARB_RR_EN: sel_data = data_req. Data has fixed priority over inst.
  - mem_req = can_issue & (inst_req | data_req).
- Mux when sel_data: mem_* = data_*.
- Mux when inst selected: mem_addr = inst_addr, mem_wr = 0, mem_wstrb = 0, mem_size = 3'd2, mem_wdata = 0.
- Address handshake:
  - data_addr_ok = mem_addr_ok & mem_req & sel_data.
  - inst_addr_ok = mem_addr_ok & mem_req & ~sel_data.
  - The non-selected requester never sees addr_ok.
- Push: mem_req & mem_addr_ok writes the tag (1=data, 0=inst) at wr_ptr, then wr_ptr++ and count++.
- Pop: mem_data_ok & (count != 0):
  - head tag 1 -> data_data_ok = 1; head tag 0 -> inst_data_ok = 1.
  - rd_ptr++ and count--.
  - inst_rdata = data_rdata = mem_rdata, unconditionally.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count == MAX_OUT): mem_req = 0 even if a pop occurs in the same cycle. New issue resumes the next cycle.
- mem_data_ok with count == 0: ignored. No data_ok is asserted and the counter does not underflow.
- Pointers wrap modulo MAX_OUT. Storage is MAX_OUT tag bits.
- Responses are in order. Downstream must return data_ok in address-accept order.
- mem_req is not held across cycles by the arbiter. Requesters keep *_req asserted until they receive addr_ok, per the sram-like protocol.
- Reset mid-transaction: the FIFO is cleared and later stray mem_data_ok pulses are ignored. The bridge is reset by the same resetn.

Optional Feature:
- Macro ARB_RR_EN.
- When defined:
  - If both requests are present, grant the source opposite last_grant.
  - last_grant updates to the granted source on each accepted address phase.
  - Single requests are granted directly.
- When undefined: fixed data priority as above, and last_grant is not implemented.

Test Plan:
- Reset, then inst_req=1, inst_addr=0xBFC00000, mem_addr_ok=1:
  - mem_addr=0xBFC00000, mem_size=2, inst_addr_ok=1 the same cycle.
  - mem_data_ok with mem_rdata=0x24080001 one cycle later -> inst_data_ok=1, inst_rdata=0x24080001, data_data_ok=0.
- inst_req and data_req together (data_wr=1, data_addr=0x80001000, data_wstrb=4'hF, data_wdata=0xDEADBEEF), ARB_RR_EN off:
  - data granted first (mem_wr=1), inst granted next cycle.
  - Two mem_data_ok pulses -> data_data_ok then inst_data_ok.
- MAX_OUT=2, mem_addr_ok=1, mem_data_ok held 0, inst_req held:
  - two accepts, then mem_req=0 and inst_addr_ok=0.
  - One mem_data_ok -> mem_req stays 0 that cycle and returns to 1 the next cycle.
- Push and pop in the same cycle with count=1 -> count stays 1, tag order preserved over 8 alternating inst/data transactions.
- mem_data_ok pulse with count=0 -> no *_data_ok.
- Assert resetn=0 with 2 outstanding, release, then issue one fetch -> its data_ok is routed to inst.
- ARB_RR_EN defined, both requests held for 4 accepts -> grant order inst, data, inst, data.
